// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for the 5-stage Y86-64 pipeline.
//
// Chooses the PC presented to fetch, owns the predicted-PC register, and
// drives the stall/bubble controls of the F, D and E pipeline registers.
// Detects load-use hazards, jXX mispredicts, and ret in flight. It drains
// the pipe after a faulting fetch and stops permanently once a non-AOK
// status reaches write-back.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   pc                 PC presented to fetch (combinational select)
//   f_*                fetch-stage decode of the instruction at pc
//   d_*, e_*, m_*, w_* later-stage feedback used for hazard detection and redirects
//   f_stall            hold pred_pc / pc
//   f_bubble           D register takes a nop instead of the fetched instruction
//   d_stall, d_bubble  D register hold / nop insert
//   e_bubble           E register nop insert
//   halted             pipeline permanently stopped (until reset)
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] pc,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        f_instr_valid,
  input  logic        f_imem_error,
  input  logic        f_hlt,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_dstM,
  input  logic        e_cnd,
  input  logic [3:0]  m_icode,
  input  logic        m_cnd,
  input  logic [63:0] m_valA,
  input  logic [3:0]  w_icode,
  input  logic [63:0] w_valM,
  input  logic [2:0]  w_stat,
  output logic        f_stall,
  output logic        f_bubble,
  output logic        d_stall,
  output logic        d_bubble,
  output logic        e_bubble,
  output logic        halted
);

  // Y86-64 instruction codes referenced here
  localparam logic [3:0] IcMrmovq = 4'd5;
  localparam logic [3:0] IcJxx    = 4'd7;
  localparam logic [3:0] IcCall   = 4'd8;
  localparam logic [3:0] IcRet    = 4'd9;
  localparam logic [3:0] IcPopq   = 4'd11;
  localparam logic [3:0] RegNone  = 4'hF;
  localparam logic [2:0] StatAok  = 3'd1;

  // Fetch sequencer states
  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;

  localparam logic [63:0] ImemLast = 64'(IMEM_BYTES) - 64'd1;

  logic [1:0]  state_q, state_d;
  logic [63:0] pred_pc_q, pred_pc_d;

  logic load_use;
  logic mispredict;
  logic ret_inflight;
  logic m_redirect;
  logic w_redirect;
  logic redirect;
  logic pc_oob;
  logic fetch_fault;
  logic [63:0] fetch_next;
  logic running;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign load_use = ((e_icode == IcMrmovq) || (e_icode == IcPopq)) &&
                    (e_dstM != RegNone) &&
                    ((e_dstM == d_srcA) || (e_dstM == d_srcB));

  assign mispredict   = (e_icode == IcJxx) && !e_cnd;
  assign ret_inflight = (d_icode == IcRet) || (e_icode == IcRet) || (m_icode == IcRet);

  // ---------------------------------------------------------------------------
  // PC select: a mispredicted jXX in M outranks a ret completing in W
  // ---------------------------------------------------------------------------
  assign m_redirect = (m_icode == IcJxx) && !m_cnd;
  assign w_redirect = (w_icode == IcRet);
  assign redirect   = m_redirect || w_redirect;

  always_comb begin
    if (m_redirect) begin
      pc = m_valA;
    end else if (w_redirect) begin
      pc = w_valM;
    end else begin
      pc = pred_pc_q;
    end
  end

  // Out-of-range pc is treated as a fault even if imem did not flag it.
  assign pc_oob      = (pc > ImemLast);
  assign fetch_fault = f_hlt || !f_instr_valid || f_imem_error || pc_oob;

  // Calls and jumps predict taken; everything else falls through.
  assign fetch_next = ((f_icode == IcJxx) || (f_icode == IcCall)) ? f_valC : f_valP;

  // ---------------------------------------------------------------------------
  // Control outputs
  // ---------------------------------------------------------------------------
  assign running  = (state_q == StRun);
  assign halted   = (state_q == StHalted);

  assign f_stall  = load_use || ret_inflight || !running;
  assign f_bubble = !running;
  assign d_stall  = load_use || halted;
  // Load-use outranks ret: D must hold the consumer rather than squash it.
  assign d_bubble = mispredict || (ret_inflight && !load_use);
  assign e_bubble = mispredict || load_use || halted;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pred_pc_d = pred_pc_q;

    unique case (state_q)
      StRun: begin
        if (!f_stall) begin
          // The faulting instruction still enters D on this edge; pred_pc
          // is frozen so nothing past it is ever fetched.
          if (fetch_fault) begin
            state_d = StDrain;
          end else begin
            pred_pc_d = fetch_next;
          end
        end
      end
      StDrain: begin
        // An older redirect squashes the fault; resume from the redirected
        // fetch. A halting status in W wins over the redirect.
        if (redirect && (w_stat == StatAok)) begin
          state_d   = StRun;
          pred_pc_d = fetch_next;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StHalted;
      end
    endcase

    if (w_stat != StatAok) begin
      state_d = StHalted;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRun;
      pred_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pred_pc_q <= pred_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Internal consistency checks
  // ---------------------------------------------------------------------------
  a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != 2'd3));

  a_halted_freezes : assert property (@(posedge clk) disable iff (!rst_n)
    halted |-> (f_stall && f_bubble && d_stall && e_bubble));

  a_drain_holds_pred : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StDrain && !redirect) |=> (pred_pc_q == $past(pred_pc_q)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed walk through the main scenarios with
// literal expectations, then randomized traffic compared every cycle against
// a behavioural model of the fetch sequencer.
module tb_fetch_ctrl;

  localparam logic [63:0] ResetPc = 64'd0;
  localparam int MRun = 0, MDrain = 1, MHalt = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc;
  logic [3:0]  f_icode;
  logic [63:0] f_valC, f_valP;
  logic        f_instr_valid, f_imem_error, f_hlt;
  logic [3:0]  d_icode, d_srcA, d_srcB;
  logic [3:0]  e_icode, e_dstM;
  logic        e_cnd;
  logic [3:0]  m_icode;
  logic        m_cnd;
  logic [63:0] m_valA;
  logic [3:0]  w_icode;
  logic [63:0] w_valM;
  logic [2:0]  w_stat;
  logic        f_stall, f_bubble, d_stall, d_bubble, e_bubble, halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int          mdl_mode  = MRun;
  logic [63:0] mdl_pred  = ResetPc;
  bit          mdl_valid = 1'b0;
  int          halt_cnt  = 0;

  fetch_ctrl #(
    .RESET_PC  (ResetPc),
    .IMEM_BYTES(1024)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .f_icode      (f_icode),
    .f_valC       (f_valC),
    .f_valP       (f_valP),
    .f_instr_valid(f_instr_valid),
    .f_imem_error (f_imem_error),
    .f_hlt        (f_hlt),
    .d_icode      (d_icode),
    .d_srcA       (d_srcA),
    .d_srcB       (d_srcB),
    .e_icode      (e_icode),
    .e_dstM       (e_dstM),
    .e_cnd        (e_cnd),
    .m_icode      (m_icode),
    .m_cnd        (m_cnd),
    .m_valA       (m_valA),
    .w_icode      (w_icode),
    .w_valM       (w_valM),
    .w_stat       (w_stat),
    .f_stall      (f_stall),
    .f_bubble     (f_bubble),
    .d_stall      (d_stall),
    .d_bubble     (d_bubble),
    .e_bubble     (e_bubble),
    .halted       (halted)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model -------------------------------------------------
  function automatic bit mdl_lu();
    return (e_icode == 4'd5 || e_icode == 4'd11) && e_dstM != 4'hF &&
           (e_dstM == d_srcA || e_dstM == d_srcB);
  endfunction

  function automatic bit mdl_mis();
    return e_icode == 4'd7 && !e_cnd;
  endfunction

  function automatic bit mdl_ret();
    return d_icode == 4'd9 || e_icode == 4'd9 || m_icode == 4'd9;
  endfunction

  function automatic logic [63:0] mdl_pc();
    if (m_icode == 4'd7 && !m_cnd) return m_valA;
    if (w_icode == 4'd9) return w_valM;
    return mdl_pred;
  endfunction

  task automatic model_check();
    bit lu, mis, rt;
    if (!mdl_valid) return;
    lu  = mdl_lu();
    mis = mdl_mis();
    rt  = mdl_ret();
    check("pc",       pc,       mdl_pc());
    check("f_stall",  64'(f_stall),  64'(lu || rt || mdl_mode != MRun));
    check("f_bubble", 64'(f_bubble), 64'(mdl_mode != MRun));
    check("d_stall",  64'(d_stall),  64'(lu || mdl_mode == MHalt));
    check("d_bubble", 64'(d_bubble), 64'(mis || (rt && !lu)));
    check("e_bubble", 64'(e_bubble), 64'(mis || lu || mdl_mode == MHalt));
    check("halted",   64'(halted),   64'(mdl_mode == MHalt));
  endtask

  task automatic model_advance();
    bit fs, fault, redir;
    logic [63:0] p, nxt;
    int nm;
    if (!rst_n) begin
      mdl_mode  = MRun;
      mdl_pred  = ResetPc;
      mdl_valid = 1'b1;
      halt_cnt  = 0;
      return;
    end
    if (!mdl_valid) return;
    p     = mdl_pc();
    fs    = mdl_lu() || mdl_ret() || mdl_mode != MRun;
    fault = f_hlt || !f_instr_valid || f_imem_error || p > 64'd1023;
    nxt   = (f_icode == 4'd7 || f_icode == 4'd8) ? f_valC : f_valP;
    redir = (m_icode == 4'd7 && !m_cnd) || w_icode == 4'd9;
    nm    = mdl_mode;
    if (mdl_mode == MRun && !fs) begin
      if (fault) nm = MDrain;
      else mdl_pred = nxt;
    end else if (mdl_mode == MDrain && redir && w_stat == 3'd1) begin
      nm = MRun;
      mdl_pred = nxt;
    end
    if (w_stat != 3'd1) nm = MHalt;
    mdl_mode = nm;
    halt_cnt = (nm == MHalt) ? halt_cnt + 1 : 0;
  endtask

  // Inputs change 1ns after posedge; outputs sampled mid-cycle.
  task automatic settle();
    #4;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_advance();
  endtask

  task automatic idle();
    f_icode = 4'd1; f_valC = '0; f_valP = '0;
    f_instr_valid = 1'b1; f_imem_error = 1'b0; f_hlt = 1'b0;
    d_icode = 4'd1; d_srcA = 4'hF; d_srcB = 4'hF;
    e_icode = 4'd1; e_dstM = 4'hF; e_cnd = 1'b1;
    m_icode = 4'd1; m_cnd = 1'b1; m_valA = '0;
    w_icode = 4'd1; w_valM = '0; w_stat = 3'd1;
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(0, 49) == 0) return {$urandom, $urandom};
    return 64'($urandom_range(0, 1100));
  endfunction

  task automatic randomize_inputs();
    f_icode       = 4'($urandom_range(0, 11));
    f_valC        = rand_addr();
    f_valP        = rand_addr();
    f_instr_valid = ($urandom_range(0, 29) != 0);
    f_imem_error  = ($urandom_range(0, 39) == 0);
    f_hlt         = ($urandom_range(0, 19) == 0);
    d_icode       = 4'($urandom_range(0, 11));
    d_srcA        = 4'($urandom_range(0, 15));
    d_srcB        = 4'($urandom_range(0, 15));
    e_icode       = 4'($urandom_range(0, 11));
    e_dstM        = $urandom_range(0, 1) ? d_srcA : 4'($urandom_range(0, 15));
    e_cnd         = 1'($urandom_range(0, 1));
    m_icode       = 4'($urandom_range(0, 11));
    m_cnd         = 1'($urandom_range(0, 1));
    m_valA        = rand_addr();
    w_icode       = 4'($urandom_range(0, 11));
    w_valM        = rand_addr();
    w_stat        = ($urandom_range(0, 149) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
    rst_n         = !(halt_cnt > 4 || $urandom_range(0, 99) == 0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    tick();
    tick();

    // 1. Reset state
    settle();
    check("rst_pc", pc, 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_ctrl", 64'({f_stall, d_stall, d_bubble, e_bubble, f_bubble}), 64'd0);
    rst_n = 1'b1;
    tick();

    // 2. Fall-through, then predicted-taken jump
    idle(); f_icode = 4'd3; f_valP = 64'd10;
    settle();
    check("seq_pc0", pc, 64'd0);
    tick();
    idle(); f_icode = 4'd7; f_valC = 64'h40; f_valP = 64'd19;
    settle();
    check("seq_pc10", pc, 64'd10);
    tick();

    // 3. Mispredict in E, then redirect from M
    idle(); e_icode = 4'd7; e_cnd = 1'b0; f_icode = 4'd3; f_valP = 64'h50;
    settle();
    check("jmp_pc40", pc, 64'h40);
    check("mis_dbub", 64'(d_bubble), 64'd1);
    check("mis_ebub", 64'(e_bubble), 64'd1);
    tick();
    idle(); m_icode = 4'd7; m_cnd = 1'b0; m_valA = 64'h2B; f_icode = 4'd3; f_valP = 64'h2D;
    settle();
    check("mis_pc", pc, 64'h2B);
    tick();

    // 4. Load-use with ret in D: stall, no D bubble
    idle(); e_icode = 4'd5; e_dstM = 4'd2; d_srcA = 4'd2; d_icode = 4'd9;
    f_icode = 4'd3; f_valP = 64'h2F;
    settle();
    check("lu_pc", pc, 64'h2D);
    check("lu_fstall", 64'(f_stall), 64'd1);
    check("lu_dstall", 64'(d_stall), 64'd1);
    check("lu_ebub", 64'(e_bubble), 64'd1);
    check("lu_dbub", 64'(d_bubble), 64'd0);
    tick();
    settle();
    check("lu_pc_held", pc, 64'h2D);
    tick();

    // 5. ret walking D -> E -> M, then return address from W
    for (int s = 0; s < 3; s++) begin
      idle(); f_icode = 4'd3; f_valP = 64'h33;
      if (s == 0) d_icode = 4'd9;
      if (s == 1) e_icode = 4'd9;
      if (s == 2) m_icode = 4'd9;
      settle();
      check("ret_fstall", 64'(f_stall), 64'd1);
      check("ret_dbub", 64'(d_bubble), 64'd1);
      check("ret_pc_held", pc, 64'h2D);
      tick();
    end
    idle(); w_icode = 4'd9; w_valM = 64'h80; f_icode = 4'd3; f_valP = 64'h82;
    settle();
    check("ret_pc", pc, 64'h80);
    check("ret_fstall_off", 64'(f_stall), 64'd0);
    tick();

    // 6. Halt fetched -> drain; mispredict redirect -> run; halt status -> halted
    idle(); f_icode = 4'd0; f_hlt = 1'b1; f_valP = 64'h83;
    settle();
    check("hlt_pc", pc, 64'h82);
    check("hlt_fbub_first", 64'(f_bubble), 64'd0);
    tick();
    idle(); f_valP = 64'h90;
    settle();
    check("drain_fbub", 64'(f_bubble), 64'd1);
    check("drain_pc", pc, 64'h82);
    tick();
    idle(); m_icode = 4'd7; m_cnd = 1'b0; m_valA = 64'h100; f_icode = 4'd3; f_valP = 64'h10A;
    settle();
    check("drain_redir_pc", pc, 64'h100);
    tick();
    idle(); f_icode = 4'd0; f_hlt = 1'b1; w_stat = 3'd2;
    settle();
    check("resume_pc", pc, 64'h10A);
    check("resume_fbub", 64'(f_bubble), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      idle();
      settle();
      check("halted", 64'(halted), 64'd1);
      check("halt_ctrl", 64'({f_stall, f_bubble, d_stall, e_bubble}), 64'hF);
      tick();
    end
    idle(); rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("post_rst_halted", 64'(halted), 64'd0);
    check("post_rst_pc", pc, 64'd0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      randomize_inputs();
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
